room_sequencer: RTL and testbench
=================================

Name: room_sequencer

Overview:
- Sequences the room map generators of the VGA game across a row of rooms (room 0 at the left, room NUM_ROOMS-1 at the right).
- Tracks the current room and selects that room's generator output as the pixel map colour.
- Runs a frame-aligned room transition: exit request, then a blanking interval, then a room switch, then a player respawn.
- Sits between the per-room map generators (for example, the hallway tiles) and the colour output stage.

Parameters:
- NUM_ROOMS, 4, number of rooms; legal range 2..16.
- BLANK_FRAMES, 8, number of full frames output black during a transition; legal range 1..255.
- SPAWN_L_X, 10'd48, player X after entering a room through its left edge.
- SPAWN_R_X, 10'd584, player X after entering a room through its right edge.
- SPAWN_Y, 9'd240, player Y after any transition.
- RW, max(1, clog2(NUM_ROOMS)), room index width; derived, must not be overridden.

Ports:
- clk_vga  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the first pixel of each frame
- exit_valid  in  1  one-cycle pulse: the player crossed an open room edge
- exit_dir  in  2  0 = left, 1 = right, 2 = up, 3 = down; valid with exit_valid
- room_map_data  in  NUM_ROOMS*8  map colour from each room generator; room k occupies bits [8k+7:8k]
- mapData  out  8  registered map colour to the output stage
- room_idx  out  RW  current room
- blanking  out  1  high while the transition is blanking the screen
- busy  out  1  high in ARMED or BLANK
- spawn_valid  out  1  one-cycle pulse carrying the new player position
- spawn_x  out  10  valid with spawn_valid
- spawn_y  out  9  valid with spawn_valid

Behaviour:
- Clock and reset: one clock, clk_vga. rst_n is asynchronous and active-low.
- Reset values:
  - state = PLAY, room_idx = 0, mapData = 8'h00.
  - blanking = 0, busy = 0, spawn_valid = 0, spawn_x = 0, spawn_y = 0.
  - Frame counter = 0, latched direction = 0.
- mapData: one-cycle latency, updated every clock.
  - mapData <= blanking ? 8'h00 : room_map_data[8*room_idx +: 8].
  - Both blanking and room_idx are taken as their pre-edge register values.
- State PLAY:
  - On exit_valid with exit_dir = 0 (left) and room_idx > 0: latch the direction, go to ARMED.
  - On exit_valid with exit_dir = 1 (right) and room_idx < NUM_ROOMS-1: latch the direction, go to ARMED.
  - All other exits are ignored and the state stays PLAY. This covers up, down, left from room 0, and right from the last room.
- State ARMED:
  - Wait for frame_start.
  - A frame_start in the same cycle as the exit_valid that caused the PLAY to ARMED transition does not count.
  - On frame_start: go to BLANK, set blanking = 1, set frame counter = 0.
  - Update room_idx in this same cycle: room_idx - 1 for left, room_idx + 1 for right.
- State BLANK:
  - Each frame_start increments the frame counter.
  - On the frame_start that brings the counter to BLANK_FRAMES: go to PLAY, clear blanking, pulse spawn_valid for one cycle.
  - Spawn position after a right exit: spawn_x = SPAWN_L_X (the player enters on the left edge).
  - Spawn position after a left exit: spawn_x = SPAWN_R_X.
  - spawn_y = SPAWN_Y in both cases.
- busy = (state != PLAY).
- exit_valid is ignored in ARMED and BLANK; there is no queuing.
- Blanking length is exactly BLANK_FRAMES whole frames, measured from the entering frame_start.
- room_idx never wraps and never leaves 0..NUM_ROOMS-1.
- spawn_x and spawn_y hold their last values between pulses.
- Reset asserted mid-transition: everything returns immediately to the reset values. There is no spawn pulse, and room_idx = 0.
- Generator outputs for rooms beyond NUM_ROOMS do not exist; no X may reach mapData.

Test Plan:
- Post-reset with room_map_data = {8'h44, 8'h33, 8'h22, 8'h11}: room_idx = 0, and mapData = 8'h11 from the second clock onward.
- Exit right in room 0, then frame_start: room_idx = 1 and blanking = 1 in the same cycle. mapData = 8'h00 for the next 8 frames. On the 8th following frame_start: spawn_valid pulses with spawn_x = 48 and spawn_y = 240, then mapData = 8'h22.
- Exit left in room 0, exit right in room 3, and exit_dir = 2 or 3 in any room: no state change, busy stays 0.
- exit_valid coincident with frame_start in PLAY: the switch happens only on the next frame_start. An exit_valid during BLANK is dropped, and room_idx changes by exactly 1.
- From room 2, exit left: room_idx = 1 and spawn_x = 584.
- Assert rst_n low in BLANK on frame 4: room_idx = 0, blanking = 0, busy = 0, no spawn_valid pulse, and mapData = 8'h00, then 8'h11 after release.

Source files
------------

// File: rtl/room_sequencer_if.sv
// -----------------------------------------------------------------------------
// room_sequencer_if
//   Bundles the signals between the room sequencer, the game logic that raises
//   exits and consumes respawns, the per-room map generators and the colour
//   output stage.
//
//   master : game / generator side (drives frame timing, exits, room colours)
//   slave  : room_sequencer
//
//   frame_start    1-cycle pulse at the first pixel of each frame
//   exit_valid     1-cycle pulse, player crossed an open room edge
//   exit_dir       0 left, 1 right, 2 up, 3 down (valid with exit_valid)
//   room_map_data  NUM_ROOMS x 8-bit generator colours, room k at [8k+7:8k]
//   mapData        registered map colour towards the output stage
//   room_idx       current room
//   blanking       screen is being blanked by a transition
//   busy           a transition is armed or blanking
//   spawn_valid    1-cycle pulse carrying the new player position
//   spawn_x/_y     player position, valid with spawn_valid
// -----------------------------------------------------------------------------
interface room_sequencer_if #(
    parameter int  NUM_ROOMS = 4,
    localparam int RW        = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
);
    logic                   frame_start;
    logic                   exit_valid;
    logic [1:0]             exit_dir;
    logic [NUM_ROOMS*8-1:0] room_map_data;
    logic [7:0]             mapData;
    logic [RW-1:0]          room_idx;
    logic                   blanking;
    logic                   busy;
    logic                   spawn_valid;
    logic [9:0]             spawn_x;
    logic [8:0]             spawn_y;

    modport master (
        output frame_start, exit_valid, exit_dir, room_map_data,
        input  mapData, room_idx, blanking, busy, spawn_valid, spawn_x, spawn_y
    );

    modport slave (
        input  frame_start, exit_valid, exit_dir, room_map_data,
        output mapData, room_idx, blanking, busy, spawn_valid, spawn_x, spawn_y
    );
endinterface

// File: rtl/room_sequencer.sv
// -----------------------------------------------------------------------------
// room_sequencer
//   Walks the player along a row of rooms (room 0 leftmost). Selects the current
//   room's generator colour as the map colour and runs a frame-aligned room
//   transition: exit request -> wait for frame start -> BLANK_FRAMES black
//   frames -> respawn pulse at the edge the player entered through.
//
//   Ports:
//     clk_vga  pixel clock
//     rst_n    asynchronous active-low reset
//     bus      room_sequencer_if.slave (frame timing, exits, generator colours
//              in; map colour, room index, blanking, busy, spawn out)
// -----------------------------------------------------------------------------
module room_sequencer #(
    parameter int          NUM_ROOMS    = 4,
    parameter int          BLANK_FRAMES = 8,
    parameter logic [9:0]  SPAWN_L_X    = 10'd48,
    parameter logic [9:0]  SPAWN_R_X    = 10'd584,
    parameter logic [8:0]  SPAWN_Y      = 9'd240,
    localparam int         RW           = (NUM_ROOMS > 1) ? $clog2(NUM_ROOMS) : 1
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    room_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        ARMED = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [RW-1:0] LAST_ROOM = RW'(NUM_ROOMS - 1);

    state_t        state;
    logic [RW-1:0] room_q;
    logic          dir_right;   // latched exit direction: 1 = right, 0 = left
    logic [7:0]    frame_cnt;
    logic          blank_q;
    logic          busy_q;
    logic [7:0]    map_q;
    logic          spawn_v_q;
    logic [9:0]    spawn_x_q;
    logic [8:0]    spawn_y_q;

    logic [7:0]    room_colour;
    logic          exit_ok;
    logic          last_frame;

    // Neighbouring room, clamped to the row so room_idx can never wrap.
    function automatic logic [RW-1:0] step_room(input logic [RW-1:0] r,
                                                input logic          right);
        if (right)
            step_room = (r == LAST_ROOM) ? r : r + RW'(1);
        else
            step_room = (r == '0) ? r : r - RW'(1);
    endfunction

    // Only existing generators are selectable; an index with no generator
    // behind it yields black instead of an out-of-range slice.
    always_comb begin
        room_colour = 8'h00;
        for (int k = 0; k < NUM_ROOMS; k++) begin
            if (room_q == RW'(k))
                room_colour = bus.room_map_data[8*k +: 8];
        end
    end

    // Only a left/right exit through an edge that has a neighbour starts a move.
    assign exit_ok = bus.exit_valid &&
                     (((bus.exit_dir == 2'd0) && (room_q != '0)) ||
                      ((bus.exit_dir == 2'd1) && (room_q != LAST_ROOM)));

    // Widened compare so BLANK_FRAMES = 255 cannot overflow the counter.
    assign last_frame = (({1'b0, frame_cnt} + 9'd1) == 9'(BLANK_FRAMES));

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PLAY;
            room_q    <= '0;
            dir_right <= 1'b0;
            frame_cnt <= 8'd0;
            blank_q   <= 1'b0;
            busy_q    <= 1'b0;
            map_q     <= 8'h00;
            spawn_v_q <= 1'b0;
            spawn_x_q <= 10'd0;
            spawn_y_q <= 9'd0;
        end else begin
            // Colour stage: uses the pre-edge room and blanking values.
            map_q     <= blank_q ? 8'h00 : room_colour;
            spawn_v_q <= 1'b0;

            unique case (state)
                PLAY: begin
                    if (exit_ok) begin
                        dir_right <= bus.exit_dir[0];
                        state     <= ARMED;
                        busy_q    <= 1'b1;
                    end
                end
                ARMED: begin
                    // The frame_start that coincided with the exit was seen in
                    // PLAY, so only a later frame start reaches this branch.
                    if (bus.frame_start) begin
                        state     <= BLANK;
                        blank_q   <= 1'b1;
                        frame_cnt <= 8'd0;
                        room_q    <= step_room(room_q, dir_right);
                    end
                end
                BLANK: begin
                    if (bus.frame_start) begin
                        if (last_frame) begin
                            state     <= PLAY;
                            blank_q   <= 1'b0;
                            busy_q    <= 1'b0;
                            spawn_v_q <= 1'b1;
                            // Moving right means entering the new room on its
                            // left edge, and vice versa.
                            spawn_x_q <= dir_right ? SPAWN_L_X : SPAWN_R_X;
                            spawn_y_q <= SPAWN_Y;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= PLAY;
                    blank_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mapData     = map_q;
    assign bus.room_idx    = room_q;
    assign bus.blanking    = blank_q;
    assign bus.busy        = busy_q;
    assign bus.spawn_valid = spawn_v_q;
    assign bus.spawn_x     = spawn_x_q;
    assign bus.spawn_y     = spawn_y_q;

endmodule

// File: tb/tb_room_sequencer.sv
// -----------------------------------------------------------------------------
// tb_room_sequencer
//   Scoreboard bench for room_sequencer. The stimulus process drives inputs,
//   advances a transition-level reference model and queues the expected outputs
//   for each clock; a monitor pops and compares on the falling edge, and checks
//   every spawn pulse against a separate queue of predicted respawns.
// -----------------------------------------------------------------------------
module tb_room_sequencer;
    localparam int NR = 4;
    localparam int BF = 8;
    localparam int FL = 16;     // clocks per frame in this bench
    localparam int RW = 2;

    localparam int M_PLAY = 0;  // walking around
    localparam int M_WAIT = 1;  // exit accepted, waiting for the frame edge
    localparam int M_DARK = 2;  // screen dark, counting down frames

    logic clk_vga = 1'b0;
    logic rst_n   = 1'b1;
    always #5 clk_vga = ~clk_vga;

    room_sequencer_if #(.NUM_ROOMS(NR)) bus ();

    room_sequencer #(.NUM_ROOMS(NR), .BLANK_FRAMES(BF)) dut (
        .clk_vga (clk_vga),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0]    map;
        logic [RW-1:0] room;
        logic          blank;
        logic          busy;
        logic          sv;
        logic [9:0]    sx;
        logic [8:0]    sy;
    } exp_t;

    typedef struct packed {
        logic [9:0]    x;
        logic [8:0]    y;
        logic [RW-1:0] room;
    } spawn_t;

    exp_t   exp_q[$];
    spawn_t spawn_q[$];

    int errors = 0;
    int checks = 0;
    int n_spawn_exp = 0;
    int n_spawn_seen = 0;

    // Reference model: transition-level view of the room walk.
    int         m_mode;
    int         m_room;
    bit         m_dir_right;
    int         m_frames_left;
    bit         m_blank;
    logic [7:0] m_map;
    bit         m_sv;
    logic [9:0] m_sx;
    logic [8:0] m_sy;

    logic [8*NR-1:0] colours;
    int phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function void model_reset();
        m_mode        = M_PLAY;
        m_room        = 0;
        m_dir_right   = 1'b0;
        m_frames_left = 0;
        m_blank       = 1'b0;
        m_map         = 8'h00;
        m_sv          = 1'b0;
        m_sx          = 10'd0;
        m_sy          = 9'd0;
    endfunction

    task automatic model_clock(input bit fs, input bit ev, input int dir, input logic [8*NR-1:0] col);
        logic [7:0] sel;
        sel   = col[8*m_room +: 8];
        m_map = m_blank ? 8'h00 : sel;
        m_sv  = 1'b0;
        if (m_mode == M_PLAY) begin
            if (ev && ((dir == 0 && m_room > 0) || (dir == 1 && m_room < NR-1))) begin
                m_mode      = M_WAIT;
                m_dir_right = (dir == 1);
            end
        end else if (m_mode == M_WAIT) begin
            if (fs) begin
                m_mode        = M_DARK;
                m_blank       = 1'b1;
                m_frames_left = BF;
                m_room        = m_room + (m_dir_right ? 1 : -1);
            end
        end else begin
            if (fs) begin
                m_frames_left--;
                if (m_frames_left == 0) begin
                    m_mode  = M_PLAY;
                    m_blank = 1'b0;
                    m_sv    = 1'b1;
                    m_sx    = m_dir_right ? 10'd48 : 10'd584;
                    m_sy    = 9'd240;
                    spawn_q.push_back('{m_sx, m_sy, RW'(m_room)});
                    n_spawn_exp++;
                end
            end
        end
    endtask

    task automatic step(input bit fs, input bit ev, input logic [1:0] dir);
        bus.frame_start   = fs;
        bus.exit_valid    = ev;
        bus.exit_dir      = dir;
        bus.room_map_data = colours;
        if (!rst_n) model_reset();
        else        model_clock(fs, ev, int'(dir), colours);
        @(posedge clk_vga);
        #1;
        exp_q.push_back('{m_map, RW'(m_room), m_blank, (m_mode != M_PLAY), m_sv, m_sx, m_sy});
    endtask

    task automatic tick(input bit ev, input logic [1:0] dir);
        bit fs;
        fs    = (phase == FL-1);
        phase = (phase + 1) % FL;
        step(fs, ev, dir);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0);
    endtask

    task automatic wait_phase(input int p);
        while (phase != p) tick(1'b0, 2'd0);
    endtask

    task automatic do_exit(input logic [1:0] dir);
        wait_phase(3);
        tick(1'b1, dir);
        run_idle(FL * (BF + 2));
    endtask

    task automatic async_reset_mid();
        @(negedge clk_vga);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_room",   32'(bus.room_idx),    32'd0);
        check("async_blank",  32'(bus.blanking),    32'd0);
        check("async_busy",   32'(bus.busy),        32'd0);
        check("async_spawn",  32'(bus.spawn_valid), 32'd0);
        check("async_map",    32'(bus.mapData),     32'd0);
    endtask

    // Monitor: per-clock scoreboard plus spawn-pulse scoreboard.
    always @(negedge clk_vga) begin : monitor
        exp_t   e;
        spawn_t s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mapData",     32'(bus.mapData),     32'(e.map));
            check("room_idx",    32'(bus.room_idx),    32'(e.room));
            check("blanking",    32'(bus.blanking),    32'(e.blank));
            check("busy",        32'(bus.busy),        32'(e.busy));
            check("spawn_valid", 32'(bus.spawn_valid), 32'(e.sv));
            check("spawn_x",     32'(bus.spawn_x),     32'(e.sx));
            check("spawn_y",     32'(bus.spawn_y),     32'(e.sy));
        end
        if (bus.spawn_valid === 1'b1) begin
            n_spawn_seen++;
            if (spawn_q.size() == 0) begin
                check("unexpected_spawn", 32'd1, 32'd0);
            end else begin
                s = spawn_q.pop_front();
                check("spawn_pulse_x",    32'(bus.spawn_x),  32'(s.x));
                check("spawn_pulse_y",    32'(bus.spawn_y),  32'(s.y));
                check("spawn_pulse_room", 32'(bus.room_idx), 32'(s.room));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bus.frame_start   = 1'b0;
        bus.exit_valid    = 1'b0;
        bus.exit_dir      = 2'd0;
        colours           = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.room_map_data = colours;
        model_reset();

        #1 rst_n = 1'b0;
        #1;
        check("reset_room",    32'(bus.room_idx),    32'd0);
        check("reset_map",     32'(bus.mapData),     32'd0);
        check("reset_blank",   32'(bus.blanking),    32'd0);
        check("reset_busy",    32'(bus.busy),        32'd0);
        check("reset_spawn",   32'(bus.spawn_valid), 32'd0);
        check("reset_spawn_x", 32'(bus.spawn_x),     32'd0);
        check("reset_spawn_y", 32'(bus.spawn_y),     32'd0);

        run_idle(3);
        rst_n = 1'b1;
        run_idle(5);

        // Exits that must be ignored in room 0.
        wait_phase(2);
        tick(1'b1, 2'd0);
        run_idle(3);
        tick(1'b1, 2'd2);
        tick(1'b1, 2'd3);
        run_idle(FL);

        // Room 0 -> 1.
        do_exit(2'd1);

        // Exit coincident with frame_start, then an exit dropped during blank.
        wait_phase(FL-1);
        tick(1'b1, 2'd1);
        run_idle(FL * 3);
        tick(1'b1, 2'd1);
        tick(1'b1, 2'd0);
        run_idle(FL * (BF + 1));

        // Room 2 -> 3, right from the last room ignored, then walk back left.
        do_exit(2'd1);
        do_exit(2'd1);
        tick(1'b1, 2'd2);
        run_idle(FL);
        do_exit(2'd0);
        do_exit(2'd0);

        // Reset in the middle of blanking.
        wait_phase(3);
        tick(1'b1, 2'd1);
        run_idle(FL * 4 + 5);
        async_reset_mid();
        run_idle(3);
        rst_n = 1'b1;
        run_idle(FL * (BF + 2));

        // Random traffic with random generator colours.
        for (int i = 0; i < 3000; i++) begin
            colours = $urandom;
            tick(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
        end
        colours = {8'h44, 8'h33, 8'h22, 8'h11};
        run_idle(FL * (BF + 2));

        @(negedge clk_vga);
        #1;
        check("exp_queue_drained", 32'(exp_q.size()),   32'd0);
        check("spawn_queue_drained", 32'(spawn_q.size()), 32'd0);
        check("spawn_count", 32'(n_spawn_seen), 32'(n_spawn_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
